// File: rtl/gray_code_tracker.sv
// Gray-code receive tracker: decodes each accepted sample, classifies it as an up/down step,
// no change or an illegal jump, and keeps a signed position and a saturating error count.
module gray_code_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear_err,
  output logic             locked,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_up,
  output logic             step_down,
  output logic             err,
  output logic [POS_W-1:0] position,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e           r_state,   w_state;
  logic [WIDTH-1:0] r_bin,     w_bin_next;
  logic             r_up,      w_up;
  logic             r_dn,      w_dn;
  logic             r_err,     w_err;
  logic [POS_W-1:0] r_pos,     w_pos;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_diff;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(gray_in >> i);
    end
  end

  assign w_diff = w_bin - r_bin;

  always_comb begin
    w_state    = r_state;
    w_bin_next = r_bin;
    w_up       = 1'b0;
    w_dn       = 1'b0;
    w_err      = 1'b0;
    w_pos      = r_pos;
    w_err_cnt  = r_err_cnt;

    unique case (r_state)
      StUnlocked: begin
        if (in_valid) begin
          w_bin_next = w_bin;
          w_state    = StLocked;
        end
      end
      StLocked: begin
        if (in_valid) begin
          w_bin_next = w_bin;
          if (w_diff == WIDTH'(1)) begin
            w_up  = 1'b1;
            w_pos = r_pos + POS_W'(1);
          end else if (w_diff == {WIDTH{1'b1}}) begin
            w_dn  = 1'b1;
            w_pos = r_pos - POS_W'(1);
          end else if (w_diff != '0) begin
            w_err = 1'b1;
          end
        end
      end
      default: w_state = StUnlocked;
    endcase

    // A clear coinciding with an error still records that error.
    if (clear_err) begin
      w_err_cnt = w_err ? ERR_W'(1) : '0;
    end else if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
      w_err_cnt = r_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StUnlocked;
      r_bin     <= '0;
      r_up      <= 1'b0;
      r_dn      <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_bin     <= w_bin_next;
      r_up      <= w_up;
      r_dn      <= w_dn;
      r_err     <= w_err;
      r_pos     <= w_pos;
      r_err_cnt <= w_err_cnt;
    end
  end

  assign locked    = (r_state == StLocked);
  assign bin_out   = r_bin;
  assign step_up   = r_up;
  assign step_down = r_dn;
  assign err       = r_err;
  assign position  = r_pos;
  assign err_count = r_err_cnt;

endmodule

// File: doc/gray_code_tracker.md
# gray_code_tracker

Receive-side companion to the Gray-code counter: samples a WIDTH-bit reflected-binary Gray code (counter output, rotary/position sensor, or a cross-domain pointer), converts it to binary, and classifies each accepted sample as a legal up step, a legal down step, no change, or an illegal transition. It keeps a signed position accumulator and a saturating error counter. The block sits downstream of any Gray-coded source that needs decoding and integrity checking.

## Interface
- WIDTH, 4: Gray code width in bits; legal range is 2 or more.
- POS_W, 16: width of the signed position accumulator.
- ERR_W, 8: width of the saturating error counter.

- clk  in  1  system clock; all activity on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies gray_in for the current cycle.
- gray_in  in  WIDTH  Gray-coded sample.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  a reference sample is held.
- bin_out  out  WIDTH  binary value of the last accepted sample.
- step_up  out  1  one-cycle pulse: legal +1 transition.
- step_down  out  1  one-cycle pulse: legal -1 transition.
- err  out  1  one-cycle pulse: illegal transition.
- position  out  POS_W  signed step accumulator (two's complement).
- err_count  out  ERR_W  count of illegal transitions; saturates at all-ones.

## Operation
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i]. The decode is combinational on gray_in; all outputs are registered.
- The FSM has two states, UNLOCKED and LOCKED.
- Reset enters UNLOCKED.
- UNLOCKED with in_valid=1:
  - bin_out <= decode(gray_in); go to LOCKED.
  - No step or err pulse; position unchanged.
- UNLOCKED with in_valid=0: hold.
- LOCKED with in_valid=1: compute d = decode(gray_in) - bin_out, modulo 2^WIDTH.
  - d=0: no pulse; nothing changes.
  - d=1: step_up=1; bin_out updates; position += 1.
  - d=2^WIDTH-1: step_down=1; bin_out updates; position -= 1.
  - Any other d: err=1; bin_out updates to the new value (resynchronize); position unchanged; err_count += 1 unless already all-ones.
- LOCKED with in_valid=0: all state held; all pulses 0.
- At most one of step_up, step_down, err is high in any cycle.
- Wrap-around is legal:
  - Gray of 2^WIDTH-1 followed by Gray of 0 is step_up.
  - The reverse is step_down.
- position wraps modulo 2^POS_W (no saturation).
- clear_err in the same cycle as an err event: err_count <= 1. clear_err alone: err_count <= 0. clear_err does not affect any other state.
- LOCKED is left only by reset.

## Timing
- Latency: a sample accepted at edge N produces bin_out, pulses, position and err_count valid after edge N (one cycle).
- Pulses last exactly one cycle per accepted sample. Back-to-back valid samples produce back-to-back pulses; no bubbles are required.
- Reset values: locked=0, bin_out=0, step_up=0, step_down=0, err=0, position=0, err_count=0.
- Reset has priority over in_valid and clear_err.
- Reset asserted mid-stream clears all state at that edge. The first valid sample after reset deasserts is a capture, not a step.
- No backpressure: every cycle with in_valid=1 is consumed.

## Test plan
- Reset, then in_valid=1 with gray_in=0000 → next cycle locked=1, bin_out=0, no pulses, position=0.
- Sixteen ascending Gray samples 0001, 0011, 0010, …, 1000, 0000 → sixteen step_up pulses; bin_out ends at 0; position=16; err_count=0.
- From 0000, apply 1000 then 1001 → step_down twice; bin_out=14; position=14.
- Illegal jump 0000→0011 (binary 0→2) → err=1, err_count=1, bin_out=2, position unchanged. Then 0010 → step_up with bin_out=3.
- Idle and hold checks:
  - in_valid=0 with random gray_in → no outputs change.
  - Repeated identical valid sample → no pulses.
- Counter limits and mid-stream reset:
  - ERR_W=2: five illegal jumps → err_count stays 3.
  - clear_err coincident with an error → err_count=1.
  - Reset mid-stream → all outputs return to reset values; the next sample is a capture.
